// File: rtl/line_main_mem_if.sv
// rtl/line_main_mem_if.sv - line-granular request/grant bus between cache and main memory
interface line_main_mem_if #(
    parameter int LINE_ADDR_LEN = 3,
    parameter int ADDR_LEN      = 9
);
    localparam int LINE_SIZE = 1 << LINE_ADDR_LEN;

    logic                gnt;
    logic [ADDR_LEN-1:0] addr;
    logic                rd_req;
    logic [31:0]         rd_line [LINE_SIZE];
    logic                wr_req;
    logic [31:0]         wr_line [LINE_SIZE];
    logic [31:0]         rd_cnt;
    logic [31:0]         wr_cnt;

    // Requester side (the cache)
    modport master (
        output addr, rd_req, wr_req, wr_line,
        input  gnt, rd_line, rd_cnt, wr_cnt
    );

    // Responder side (the memory model)
    modport slave (
        input  addr, rd_req, wr_req, wr_line,
        output gnt, rd_line, rd_cnt, wr_cnt
    );
endinterface

// File: rtl/line_main_mem.sv
// rtl/line_main_mem.sv - fixed-latency whole-line main memory with transaction counters
module line_main_mem #(
    parameter int LINE_ADDR_LEN = 3,
    parameter int ADDR_LEN      = 9,
    parameter int LATENCY       = 4
) (
    input  logic             clk,
    input  logic             rst,
    line_main_mem_if.slave   bus
);
    localparam int LINE_SIZE = 1 << LINE_ADDR_LEN;
    localparam int NLINES    = 1 << ADDR_LEN;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]          r_state;
    logic [7:0]          r_cnt;
    logic                r_op_wr;
    logic [ADDR_LEN-1:0] r_addr;
    logic [31:0]         r_wr_line [LINE_SIZE];
    logic [31:0]         r_rd_line [LINE_SIZE];
    logic                r_gnt;
    logic [31:0]         r_rd_cnt;
    logic [31:0]         r_wr_cnt;

    // Storage only holds lines that have been written; a never-written line
    // reads back as its own word addresses, which is the power-up contents.
    // Neither the array nor the written flags are touched by rst.
    logic [31:0]         r_mem [NLINES][LINE_SIZE];
    logic [NLINES-1:0]   r_written = '0;

    logic                w_do_op;
    logic [31:0]         w_rd_word [LINE_SIZE];

    assign w_do_op = (r_state == S_BUSY) && (r_cnt == 8'd0);

    // Line read data: stored contents if written, else the preset word address
    always_comb begin
        for (int w = 0; w < LINE_SIZE; w++) begin
            w_rd_word[w] = r_written[r_addr] ? r_mem[r_addr][w]
                                             : 32'({r_addr, LINE_ADDR_LEN'(w)});
        end
    end

    // Array update at the end of a write transaction
    always_ff @(posedge clk) begin
        if (w_do_op && r_op_wr) begin
            r_mem[r_addr]     <= r_wr_line;
            r_written[r_addr] <= 1'b1;
        end
    end

    // Transaction FSM: accept, count down the latency, perform, pulse gnt
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= 8'd0;
            r_op_wr  <= 1'b0;
            r_addr   <= '0;
            r_gnt    <= 1'b0;
            r_rd_cnt <= 32'd0;
            r_wr_cnt <= 32'd0;
            for (int w = 0; w < LINE_SIZE; w++) begin
                r_wr_line[w] <= 32'd0;
                r_rd_line[w] <= 32'd0;
            end
        end else begin
            r_gnt <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // Write wins when both are requested; a held read is
                    // picked up as a fresh transaction afterwards.
                    if (bus.wr_req) begin
                        r_op_wr   <= 1'b1;
                        r_addr    <= bus.addr;
                        r_wr_line <= bus.wr_line;
                        r_cnt     <= 8'(LATENCY - 2);
                        r_state   <= S_BUSY;
                    end else if (bus.rd_req) begin
                        r_op_wr <= 1'b0;
                        r_addr  <= bus.addr;
                        r_cnt   <= 8'(LATENCY - 2);
                        r_state <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    // Completes even if the requester has since dropped req
                    if (r_cnt == 8'd0) begin
                        r_gnt   <= 1'b1;
                        r_state <= S_DONE;
                        if (r_op_wr) begin
                            r_wr_cnt <= r_wr_cnt + 32'd1;
                        end else begin
                            r_rd_cnt  <= r_rd_cnt + 32'd1;
                            r_rd_line <= w_rd_word;
                        end
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.gnt     = r_gnt;
    assign bus.rd_line = r_rd_line;
    assign bus.rd_cnt  = r_rd_cnt;
    assign bus.wr_cnt  = r_wr_cnt;
endmodule
